pipelined_adder: RTL

Parametrised, pipelined two's-complement adder/subtractor, the multi-bit successor of the 4-bit ripple and lookahead adders. Operands are split into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. A valid/ready handshake on both sides supports full-rate streaming with backpressure. Status flags (carry, signed overflow, zero) are produced with each result. It is the arithmetic building block for the datapath's accumulators and address generators.

---
 rtl/pipelined_adder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit lookahead slice per stage,
// registered carry between stages, valid/ready handshake with whole-pipe stall.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / CHUNK;

    // Returns {carry into slice MSB ^ carry out, carry out, sum slice}.
    function automatic logic [CHUNK+1:0] slice_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             prod;
        g = x & y;
        p = x | y;
        c = '0;
        c[0] = ci;
        // Each carry is a flat sum-of-products of g/p terms, not a ripple of c[i].
        for (int unsigned i = 0; i < CHUNK; i++) begin
            prod = 1'b1;
            c[i+1] = 1'b0;
            for (int unsigned j = 0; j <= i; j++) begin
                c[i+1] = c[i+1] | (g[i-j] & prod);
                prod   = prod & p[i-j];
            end
            c[i+1] = c[i+1] | (prod & ci);
        end
        return {c[CHUNK] ^ c[CHUNK-1], c[CHUNK], x ^ y ^ c[CHUNK-1:0]};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] b_r   [STAGES];
    logic [WIDTH-1:0] res_r [STAGES];
    logic [WIDTH-1:0] res_n [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] sub_r;
    logic [STAGES-1:0] cy_r;
    logic [STAGES-1:0] zs_r;
    logic [STAGES-1:0] co_n;
    logic [STAGES-1:0] zs_n;
    logic              ovf_n;
    logic [CHUNK+1:0]  sl;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    always_comb begin
        co_n  = '0;
        zs_n  = '0;
        ovf_n = 1'b0;
        sl    = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sl = slice_add(a_r[k][k*CHUNK +: CHUNK],
                           b_r[k][k*CHUNK +: CHUNK] ^ {CHUNK{sub_r[k]}},
                           cy_r[k]);
            res_n[k] = res_r[k];
            res_n[k][k*CHUNK +: CHUNK] = sl[CHUNK-1:0];
            co_n[k] = sl[CHUNK];
            zs_n[k] = zs_r[k] && (sl[CHUNK-1:0] == '0);
            if (k == STAGES - 1) begin
                ovf_n = sl[CHUNK+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
            f         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            vld[0]   <= in_valid;
            a_r[0]   <= a;
            b_r[0]   <= b;
            sub_r[0] <= sub;
            cy_r[0]  <= cin;
            res_r[0] <= '0;
            zs_r[0]  <= 1'b1;
            for (int unsigned k = 1; k < STAGES; k++) begin
                vld[k]   <= vld[k-1];
                a_r[k]   <= a_r[k-1];
                b_r[k]   <= b_r[k-1];
                sub_r[k] <= sub_r[k-1];
                cy_r[k]  <= co_n[k-1];
                res_r[k] <= res_n[k-1];
                zs_r[k]  <= zs_n[k-1];
            end
            out_valid <= vld[STAGES-1];
            if (vld[STAGES-1]) begin
                f    <= res_n[STAGES-1];
                cout <= co_n[STAGES-1];
                ovf  <= ovf_n;
                zero <= zs_n[STAGES-1];
            end
        end
    end
endmodule
